// File: rtl/demux_stream_scheduler.sv
// demux_stream_scheduler
//   Takes a word stream from one producer through a valid/ready handshake,
//   resolves a destination channel at accept time (addressed or round-robin
//   over enabled channels) and offers the held word on exactly one of NCH
//   output channels. Words addressed to a disabled channel are consumed and
//   counted in a saturating drop counter.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   mode       0 = addressed (in_dest), 1 = round-robin over ch_en
//   ch_en      per-channel enable mask
//   in_valid   producer has a word
//   in_ready   block takes a word this cycle
//   in_data    producer word
//   in_dest    destination channel (addressed mode)
//   out_valid  one-hot, held word offered to channel i
//   out_ready  per-channel consumer accept
//   out_data   held word, shared by all channels
//   drop_cnt   saturating count of words dropped to disabled channels
//   busy       holding register occupied
module demux_stream_scheduler #(
  parameter int W      = 8,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [7:0]        ch_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  input  logic [2:0]        in_dest,
  output logic [7:0]        out_valid,
  input  logic [7:0]        out_ready,
  output logic [W-1:0]      out_data,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);

  localparam int NCH = 8;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e     state, state_nxt;
  logic [2:0] cur_dest;
  logic [2:0] rr_ptr;
  logic [2:0] rr_dest;
  logic [2:0] dest;
  logic       deliver;
  logic       accept;
  logic       drop;
  logic       store;
  logic       rr_hit;

  // First enabled channel strictly after rr_ptr, wrapping 7 -> 0. The last
  // candidate (i == NCH) is rr_ptr itself, so a single enabled channel is
  // granted repeatedly.
  always_comb begin
    rr_dest = rr_ptr;
    rr_hit  = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      if (!rr_hit && ch_en[rr_ptr + 3'(i)]) begin
        rr_dest = rr_ptr + 3'(i);
        rr_hit  = 1'b1;
      end
    end
  end

  // Handshake / next-state. A deliver in the same cycle frees the register,
  // so a FULL block can take the next word without a bubble.
  always_comb begin
    state_nxt = state;
    deliver   = (state == FULL) && out_ready[cur_dest];
    in_ready  = !(mode && (ch_en == '0)) && ((state == EMPTY) || deliver);
    accept    = in_valid && in_ready;
    dest      = mode ? rr_dest : in_dest;
    drop      = accept && !mode && !ch_en[in_dest];
    store     = accept && !drop;
    if (store)        state_nxt = FULL;
    else if (deliver) state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      cur_dest <= '0;
      rr_ptr   <= 3'd7;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (store) begin
        out_data <= in_data;
        cur_dest <= dest;
      end
      if (accept && mode) rr_ptr <= rr_dest;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign busy = (state == FULL);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign out_valid[c] = busy && (cur_dest == 3'(c));
  end

endmodule

// File: tb/tb_demux_stream_scheduler.sv
module tb_demux_stream_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [7:0] ch_en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic [7:0] out_valid;
  logic [7:0] out_ready;
  logic [7:0] out_data;
  logic [7:0] drop_cnt;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  demux_stream_scheduler #(.W(8), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ch_en(ch_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest(in_dest), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: one holding slot, a round-robin pointer, a drop tally.
  bit       m_full;
  bit [7:0] m_data;
  int       m_dest;
  int       m_rr;
  int       m_drops;

  function automatic int m_rr_next();
    for (int i = 1; i <= 8; i++)
      if (ch_en[(m_rr + i) % 8]) return (m_rr + i) % 8;
    return m_rr;
  endfunction

  function automatic bit m_in_ready();
    if (mode && ch_en == 8'h00) return 1'b0;
    return !m_full || out_ready[m_dest];
  endfunction

  function automatic logic [7:0] m_out_valid();
    return m_full ? 8'(1 << m_dest) : 8'h00;
  endfunction

  task automatic model_update();
    bit dlv, acc, st;
    int d;
    if (!rst_n) begin
      m_full = 0; m_data = 0; m_dest = 0; m_rr = 7; m_drops = 0;
      return;
    end
    dlv = m_full && out_ready[m_dest];
    acc = in_valid && m_in_ready();
    st  = 0;
    d   = 0;
    if (acc) begin
      if (mode) begin
        d = m_rr_next(); m_rr = d; st = 1;
      end else if (ch_en[in_dest]) begin
        d = in_dest; st = 1;
      end else if (m_drops < 255) begin
        m_drops++;
      end
    end
    if (st) begin
      m_full = 1; m_data = in_data; m_dest = d;
    end else if (dlv) begin
      m_full = 0;
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; in_valid = 0; mode = 0; ch_en = 8'hFF; out_ready = 8'hFF;
    in_data = 0; in_dest = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (out_valid !== 8'h00) $display("FAIL reset_out_valid got %h expected 00", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy); else n_pass++;
    n_checks++; if (drop_cnt !== 8'h00) $display("FAIL reset_drop_cnt got %h expected 00", drop_cnt); else n_pass++;
    n_checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data got %h expected 00", out_data); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b expected 1", in_ready); else n_pass++;
  endtask

  task automatic test_addressed();
    do_reset();
    in_valid = 1; in_data = 8'hA5; in_dest = 3;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL addr_in_ready got %b expected 1", in_ready); else n_pass++;
    tick();
    in_valid = 0;
    #1;
    n_checks++; if (out_valid !== 8'h08) $display("FAIL addr_out_valid got %h expected 08", out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'hA5) $display("FAIL addr_out_data got %h expected a5", out_data); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL addr_busy got %b expected 1", busy); else n_pass++;
    tick();
    #1;
    n_checks++; if (busy !== 1'b0 || out_valid !== 8'h00) $display("FAIL addr_after_deliver got busy=%b ov=%h expected busy=0 ov=00", busy, out_valid); else n_pass++;
    n_checks++; if (out_data !== 8'hA5) $display("FAIL addr_data_retained got %h expected a5", out_data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 8'h00;
    in_valid = 1; in_data = 8'h11; in_dest = 2;
    tick();
    in_data = 8'h22; in_dest = 5;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cycle %0d got %b expected 0", k, in_ready); else n_pass++;
      n_checks++; if (out_valid !== 8'h04 || out_data !== 8'h11) $display("FAIL bp_hold cycle %0d got ov=%h d=%h expected ov=04 d=11", k, out_valid, out_data); else n_pass++;
      tick();
    end
    out_ready = 8'h04;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL pass_in_ready got %b expected 1", in_ready); else n_pass++;
    tick();
    in_valid = 0;
    #1;
    n_checks++; if (out_valid !== 8'h20 || out_data !== 8'h22) $display("FAIL pass_next got ov=%h d=%h expected ov=20 d=22", out_valid, out_data); else n_pass++;
    out_ready = 8'hFF;
    tick();
  endtask

  task automatic test_drop();
    do_reset();
    ch_en = 8'hF7; in_valid = 1; in_dest = 3; in_data = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      n_checks++; if (out_valid !== 8'h00 || busy !== 1'b0) $display("FAIL drop_no_store %0d got ov=%h busy=%b expected ov=00 busy=0", k, out_valid, busy); else n_pass++;
    end
    in_valid = 0;
    #1;
    n_checks++; if (drop_cnt !== 8'd3) $display("FAIL drop_cnt got %0d expected 3", drop_cnt); else n_pass++;
    in_valid = 1;
    repeat (260) tick();
    in_valid = 0;
    #1;
    n_checks++; if (drop_cnt !== 8'd255) $display("FAIL drop_saturate got %0d expected 255", drop_cnt); else n_pass++;
  endtask

  task automatic test_round_robin();
    int seq[5] = '{0, 3, 5, 0, 3};
    do_reset();
    mode = 1; ch_en = 8'h29; in_valid = 1; in_data = 8'h00;
    tick();
    for (int k = 0; k < 5; k++) begin
      in_data = 8'(k + 1);
      if (k == 4) in_valid = 0;
      #1;
      n_checks++; if (out_valid !== 8'(1 << seq[k])) $display("FAIL rr_grant %0d got %h expected %h", k, out_valid, 8'(1 << seq[k])); else n_pass++;
      tick();
    end
    ch_en = 8'h00; in_valid = 1;
    #1;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rr_empty_mask got %b expected 0", in_ready); else n_pass++;
    in_valid = 0;
    tick();
  endtask

  task automatic test_mid_transfer();
    do_reset();
    out_ready = 8'h00; in_valid = 1; in_data = 8'h44; in_dest = 4;
    tick();
    in_valid = 0; ch_en = 8'hEF; mode = 1;
    repeat (3) tick();
    #1;
    n_checks++; if (out_valid !== 8'h10 || out_data !== 8'h44) $display("FAIL mid_hold got ov=%h d=%h expected ov=10 d=44", out_valid, out_data); else n_pass++;
    out_ready = 8'h10;
    tick();
    #1;
    n_checks++; if (busy !== 1'b0 || out_valid !== 8'h00) $display("FAIL mid_deliver got busy=%b ov=%h expected busy=0 ov=00", busy, out_valid); else n_pass++;
  endtask

  task automatic test_reset_full();
    do_reset();
    ch_en = 8'hF7; in_valid = 1; in_dest = 3;
    tick();
    mode = 1; ch_en = 8'hFF; out_ready = 8'hFF;
    tick();
    tick();
    in_valid = 0; out_ready = 8'h00;
    tick();
    #1;
    n_checks++; if (busy !== 1'b1 || out_valid !== 8'h02 || drop_cnt !== 8'd1) $display("FAIL rstf_pre got busy=%b ov=%h dc=%0d expected busy=1 ov=02 dc=1", busy, out_valid, drop_cnt); else n_pass++;
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    n_checks++; if (out_valid !== 8'h00 || busy !== 1'b0 || drop_cnt !== 8'h00) $display("FAIL rstf_clear got ov=%h busy=%b dc=%0d expected ov=00 busy=0 dc=0", out_valid, busy, drop_cnt); else n_pass++;
    in_valid = 1; out_ready = 8'hFF;
    tick();
    in_valid = 0;
    #1;
    n_checks++; if (out_valid !== 8'h01) $display("FAIL rstf_rr_first got %h expected 01", out_valid); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(15) == 0) mode = ~mode;
      r = $urandom_range(7);
      ch_en     = (r == 0) ? 8'h00 : (r < 3) ? 8'hFF : 8'($urandom);
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 8'($urandom);
      in_dest   = 3'($urandom);
      out_ready = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      rst_n     = ($urandom_range(199) != 0);
      #1;
      n_checks++;
      if (in_ready !== m_in_ready() || out_valid !== m_out_valid() || out_data !== m_data ||
          busy !== m_full || drop_cnt !== 8'(m_drops))
        $display("FAIL rand cyc %0d got rdy=%b ov=%h d=%h busy=%b dc=%0d expected rdy=%b ov=%h d=%h busy=%b dc=%0d",
                 cyc, in_ready, out_valid, out_data, busy, drop_cnt,
                 m_in_ready(), m_out_valid(), m_data, m_full, m_drops);
      else n_pass++;
      tick();
    end
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; mode = 0; ch_en = 8'hFF; in_valid = 0; in_data = 0; in_dest = 0; out_ready = 8'hFF;
    m_full = 0; m_data = 0; m_dest = 0; m_rr = 7; m_drops = 0;
    #1;
    test_reset();
    test_addressed();
    test_back_to_back();
    test_drop();
    test_round_robin();
    test_mid_transfer();
    test_reset_full();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
